mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences a multicycle MIPS32 datapath: shared instruction/data memory, IR, A/B/ALUOut/MDR registers, a single ALU.
- Drives every datapath enable and mux select from the opcode and the memory ready handshake.
- Sits beside the register file/ALU/memory in the MIPS top level. Replaces the single-cycle combinational decoder.

Parameters:
- TIMEOUT, 15, maximum cycles a memory state waits for mem_ready before aborting (1..255).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]
- mem_ready  input  1  memory completes current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load IR
- mem_to_reg  output  1  write-back source: 0=ALUOut, 1=MDR
- reg_dst  output  1  dest reg: 0=rt, 1=rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- alu_op  output  2  00=add, 01=sub, 10=funct
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
- state  output  4  current state encoding (debug)
- instr_done  output  1  one-cycle pulse on the final cycle of each completed instruction
- bus_err  output  1  one-cycle pulse on a memory timeout

Behaviour:
- State encodings: RST=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, ALU_WB=8, BRANCH=9, ADDI_EX=10, ADDI_WB=11, JUMP=12, HALT=13.
- Reset:
  - reset=1 at a clk edge forces state=RST and clears the wait counter. This applies mid-instruction as well; no pending write completes.
  - In RST all outputs are 0 and state=0. Next state is FETCH.
- Outputs are decoded from the state register. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write, pc_write and pc_source=00 are asserted only when mem_ready=1 (Mealy). FETCH then goes to DECODE.
  - If mem_ready=0, stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000000 (R-type) -> EXEC
  - 000100 (BEQ) -> BRANCH
  - 001000 (ADDI) -> ADDI_EX
  - 000010 (J) -> JUMP
  - any other opcode -> see Optional Feature
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready; on mem_ready assert instr_done -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
- Wait states (FETCH, MEM_RD, MEM_WR):
  - An 8-bit counter clears on state entry and increments each cycle while mem_ready=0.
  - When counter==TIMEOUT and mem_ready=0: pulse bus_err, suppress the Mealy outputs (ir_write/pc_write), go to FETCH with no register write and no instr_done.
  - mem_ready=1 in the same cycle as the timeout: mem_ready wins and no bus_err is raised.
  - A timeout in FETCH re-enters FETCH with the counter cleared.
- Cycle counts with zero-wait memory: R-type/ADDI 4, LW 5, SW 4, BEQ/J 3.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to HALT.
  - HALT drives all control outputs to 0, holds state=13 and keeps a sticky `illegal` output port (1 bit) at 1 until reset.
  - Port `illegal` exists only in this build; its reset value is 0.
- Undefined:
  - An unknown opcode in DECODE goes to FETCH and pulses instr_done, i.e. it executes as a NOP.
  - HALT is unreachable and no `illegal` port is present.

Test Plan:
- Reset: assert reset for 2 cycles mid-MEM_WR -> state=0 and all outputs 0 the cycle after; state=1 one cycle after release; no mem_write after reset.
- R-type, mem_ready tied 1: opcode=000000 -> states 1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8; instr_done pulses once; alu_op=10 in state 7.
- LW with 3-cycle wait in MEM_RD (mem_ready high on the 3rd cycle): states 1,2,3,4,4,4,5,1. mem_to_reg=1 and reg_write=1 in state 5 only; i_or_d=1 throughout state 4.
- BEQ and J: opcode=000100 -> pc_write_cond=1, pc_source=01, alu_op=01 in state 9. opcode=000010 -> pc_write=1, pc_source=10 in state 12. Each takes 3 cycles.
- Timeout: TIMEOUT=15, mem_ready held 0 in MEM_WR -> bus_err pulses exactly once after 15 wait cycles, then state=1, no instr_done. A repeat with mem_ready=1 on the timeout cycle -> no bus_err and instr_done=1.
- Illegal opcode 111111: with MIPS_CTRL_ILLEGAL_TRAP_EN -> state=13 and illegal=1, held for 20 cycles until reset. Without the macro -> returns to state 1 after DECODE with instr_done=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute and drives the datapath controls.
// Optional build macro MIPS_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes into a sticky HALT state.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       instr_done,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        StRst     = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExec    = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11,
        StJump    = 4'd12,
        StHalt    = 4'd13
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_wait;
    logic       w_timeout;

    assign w_wait    = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
    assign w_timeout = w_wait && !mem_ready && (r_cnt == TimeoutCnt);
    assign state     = r_state;

    always_comb begin
        w_state_next  = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        bus_err       = 1'b0;
        case (r_state)
            StRst: w_state_next = StFetch;
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // ready wins over a coincident timeout
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = StDecode;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OpLw, OpSw: w_state_next = StMemAddr;
                    OpRtype:    w_state_next = StExec;
                    OpBeq:      w_state_next = StBranch;
                    OpAddi:     w_state_next = StAddiEx;
                    OpJ:        w_state_next = StJump;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:    w_state_next = StHalt;
`else
                    default: begin
                        instr_done   = 1'b1;
                        w_state_next = StFetch;
                    end
`endif
                endcase
            end
            StMemAddr: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_state_next = StMemWb;
                end else if (w_timeout) begin
                    bus_err      = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StMemWb: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    w_state_next = StFetch;
                end else if (w_timeout) begin
                    bus_err      = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StExec: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                w_state_next  = StFetch;
            end
            StAddiEx: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = StAddiWb;
            end
            StAddiWb: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StJump: begin
                pc_write     = 1'b1;
                pc_source    = 2'b10;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StRst;
        endcase
    end

    // Counter restarts on every state change and on a timeout (FETCH re-entry).
    always_comb begin
        w_cnt_next = r_cnt;
        if ((w_state_next != r_state) || w_timeout) begin
            w_cnt_next = 8'd0;
        end else if (w_wait && !mem_ready) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal = r_illegal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StRst;
            r_cnt   <= 8'd0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            r_illegal <= r_illegal | (w_state_next == StHalt);
`endif
        end
    end

endmodule
